multiciclo_control: RTL and testbench
=====================================

MULTICICLO_CONTROL -- requirements
Module: multiciclo_control

Interface
REQ-001 Parameter: MEM_TIMEOUT, 8, max cycles a memory access may wait for mem_ready before trapping (1..255).
REQ-002 Parameter: CNT_W, 32, width of retired-instruction counter.
REQ-003 Parameter: ADDI_EN, 1, when 1 addi (001000) is legal; when 0 it is an illegal opcode.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 op_code  input  6  instruction[31:26] from the instruction register.
REQ-007 funct_field  input  6  instruction[5:0].
REQ-008 mem_ready  input  1  memory handshake: access completes in the cycle it is high.
REQ-009 Zero  input  1  ALU zero flag.
REQ-010 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst  output  1 each  multicycle datapath controls.
REQ-011 PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-012 ALUSrcB  output  2  00 regB, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-013 operation  output  4  ALU control: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
REQ-014 state  output  4  current FSM state encoding (debug).
REQ-015 exception  output  1  high while in TRAP.
REQ-016 instr_done  output  1  one-cycle pulse on the last cycle of each instruction.
REQ-017 instr_count  output  CNT_W  retired-instruction count.

Function
REQ-018 States/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11, TRAP 15; outputs decoded combinationally from state (Moore), except PC/memory enables gated by mem_ready as below.
REQ-019 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, operation=ADD, PCSource=00; IRWrite and PCWrite asserted only in a cycle with mem_ready=1; stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
REQ-020 DECODE: ALUSrcA=0, ALUSrcB=11, operation=ADD; next by op_code: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 000010 -> JUMP, 001000 with ADDI_EN=1 -> ADDIEX, anything else -> TRAP.
REQ-021 MEMADR: ALUSrcA=1, ALUSrcB=10, ADD; lw -> MEMRD, sw -> MEMWR.
REQ-022 MEMRD: MemRead=1, IorD=1; waits for mem_ready; -> MEMWB. MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; -> FETCH.
REQ-023 MEMWR: MemWrite=1, IorD=1; waits for mem_ready; -> FETCH.
REQ-024 EXEC: ALUSrcA=1, ALUSrcB=00; funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT; any other funct -> TRAP instead of ALUWB. ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; -> FETCH.
REQ-025 BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCWriteCond=1, PCSource=01; -> FETCH (PC written only when Zero=1, done by datapath).
REQ-026 JUMP: PCWrite=1, PCSource=10; -> FETCH.
REQ-027 ADDIEX: ALUSrcA=1, ALUSrcB=10, ADD; -> ADDIWB. ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; -> FETCH.
REQ-028 Unlisted outputs are 0 in every state; operation defaults to ADD.
REQ-029 Wait counter: cleared on entry to FETCH/MEMRD/MEMWR and on every mem_ready=1; increments each cycle waiting with mem_ready=0; when it reaches MEM_TIMEOUT with mem_ready still 0 the FSM goes to TRAP next cycle, no IRWrite/PCWrite/RegWrite issued.
REQ-030 TRAP: all controls 0, exception=1; absorbing until rst.
REQ-031 instr_done pulses in MEMWB, MEMWR (completing cycle), ALUWB, BRANCH, JUMP, ADDIWB; instr_count increments by 1 on each pulse, wraps modulo 2^CNT_W, never increments in TRAP.
REQ-032 Latency (mem_ready always 1): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.

Reset
REQ-033 rst=1 forces state=FETCH, wait counter=0, instr_count=0, exception=0, instr_done=0 immediately, independent of clk, including mid-instruction or in TRAP.
REQ-034 While rst=1 all write enables (PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite) are 0; first fetch begins on the first rising clk after rst deasserts.

Verification
REQ-035 mem_ready=1, op 100011 -> states 0,1,2,3,4,0; RegWrite=1 MemtoReg=1 only in state 4; instr_count 0->1.
REQ-036 R-type funct 100010 -> EXEC with operation=0110, ALUWB RegDst=1; funct 000111 -> TRAP, exception=1, instr_count unchanged.
REQ-037 MEM_TIMEOUT=8, mem_ready held 0 in FETCH -> 8 wait cycles then TRAP; mem_ready=1 on 7th wait cycle -> DECODE, no trap.
REQ-038 ADDI_EN=0, op 001000 -> TRAP; ADDI_EN=1 -> ADDIEX, ADDIWB, instr_done pulse.
REQ-039 beq with Zero=1 and Zero=0 -> PCWriteCond=1, PCSource=01 in BRANCH both cases, 3-cycle latency; j -> PCWrite=1 PCSource=10.
REQ-040 rst asserted asynchronously in MEMRD and in TRAP -> state=0, exception=0, instr_count=0 before next clk edge.

Source files
------------

// File: rtl/multiciclo_control.sv
// Multicycle MIPS-subset control FSM with memory-wait timeout trap and retired-instruction counter.
// Moore outputs from state; FETCH write enables and MEMWR completion are qualified by mem_ready.
module multiciclo_control #(
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 32,
  parameter bit ADDI_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op_code,
  input  logic [5:0]       funct_field,
  input  logic             mem_ready,
  input  logic             Zero,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       operation,
  output logic [3:0]       state,
  output logic             exception,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    TRAP   = 4'd15
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     st;
  state_t     nxt;
  logic [7:0] wait_cnt;
  logic       waiting;
  logic       timeout;
  logic       funct_ok;
  logic [3:0] alu_op;

  // Branch resolution happens in the datapath; the flag is not needed here.
  logic unused_zero;
  assign unused_zero = Zero;

  assign state   = st;
  assign waiting = (st == FETCH) || (st == MEMRD) || (st == MEMWR);
  // Counter reaching MEM_TIMEOUT this cycle with no ready means the access is abandoned.
  assign timeout = waiting && !mem_ready && (wait_cnt == WAIT_LAST);

  always_comb begin
    funct_ok = 1'b1;
    alu_op   = OP_ADD;
    case (funct_field)
      6'b100000: alu_op = OP_ADD;
      6'b100010: alu_op = OP_SUB;
      6'b100100: alu_op = OP_AND;
      6'b100101: alu_op = OP_OR;
      6'b101010: alu_op = OP_SLT;
      default:   funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    nxt = st;
    case (st)
      FETCH:  nxt = timeout ? TRAP : (mem_ready ? DECODE : FETCH);
      DECODE: begin
        case (op_code)
          6'b100011, 6'b101011: nxt = MEMADR;
          6'b000000:            nxt = EXEC;
          6'b000100:            nxt = BRANCH;
          6'b000010:            nxt = JUMP;
          6'b001000:            nxt = ADDI_EN ? ADDIEX : TRAP;
          default:              nxt = TRAP;
        endcase
      end
      MEMADR: nxt = (op_code == 6'b100011) ? MEMRD : MEMWR;
      MEMRD:  nxt = timeout ? TRAP : (mem_ready ? MEMWB : MEMRD);
      MEMWB:  nxt = FETCH;
      MEMWR:  nxt = timeout ? TRAP : (mem_ready ? FETCH : MEMWR);
      EXEC:   nxt = funct_ok ? ALUWB : TRAP;
      ALUWB:  nxt = FETCH;
      BRANCH: nxt = FETCH;
      JUMP:   nxt = FETCH;
      ADDIEX: nxt = ADDIWB;
      ADDIWB: nxt = FETCH;
      TRAP:   nxt = TRAP;
      default: nxt = TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= FETCH;
      wait_cnt    <= 8'd0;
      instr_count <= '0;
    end else begin
      st <= nxt;
      if (!waiting || mem_ready) wait_cnt <= 8'd0;
      else                       wait_cnt <= wait_cnt + 8'd1;
      if (instr_done) instr_count <= instr_count + 1'b1;
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    operation   = OP_ADD;
    exception   = 1'b0;
    instr_done  = 1'b0;
    case (st)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      EXEC: begin
        ALUSrcA   = 1'b1;
        operation = alu_op;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        operation   = OP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      TRAP:    exception = 1'b1;
      default: exception = 1'b1;
    endcase
    // Reset is asynchronous, so the mem_ready-qualified FETCH enables must be masked directly.
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
      instr_done  = 1'b0;
      exception   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multiciclo_control.sv
// Directed bench for multiciclo_control: table-driven instruction flows plus wait/timeout/reset sequences.
module tb_multiciclo_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op_code = 6'b100011;
  logic [5:0] funct_field = 6'b0;
  logic       mem_ready = 1'b1;
  logic       Zero = 1'b0;

  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUSrcB;
  logic [3:0] operation, state;
  logic exception, instr_done;
  logic [31:0] instr_count;

  logic n_PCWrite, n_PCWriteCond, n_IorD, n_MemRead, n_MemWrite, n_IRWrite, n_MemtoReg, n_ALUSrcA, n_RegWrite, n_RegDst;
  logic [1:0] n_PCSource, n_ALUSrcB;
  logic [3:0] n_operation, n_state;
  logic n_exception, n_instr_done;
  logic [1:0] n_instr_count;

  multiciclo_control #(.MEM_TIMEOUT(8), .CNT_W(32), .ADDI_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .funct_field(funct_field), .mem_ready(mem_ready), .Zero(Zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
    .PCSource(PCSource), .ALUSrcB(ALUSrcB), .operation(operation), .state(state), .exception(exception),
    .instr_done(instr_done), .instr_count(instr_count)
  );

  // Second instance: addi disabled and a 2-bit counter to exercise wraparound.
  multiciclo_control #(.MEM_TIMEOUT(8), .CNT_W(2), .ADDI_EN(1'b0)) dut_na (
    .clk(clk), .rst(rst), .op_code(op_code), .funct_field(funct_field), .mem_ready(mem_ready), .Zero(Zero),
    .PCWrite(n_PCWrite), .PCWriteCond(n_PCWriteCond), .IorD(n_IorD), .MemRead(n_MemRead), .MemWrite(n_MemWrite),
    .IRWrite(n_IRWrite), .MemtoReg(n_MemtoReg), .ALUSrcA(n_ALUSrcA), .RegWrite(n_RegWrite), .RegDst(n_RegDst),
    .PCSource(n_PCSource), .ALUSrcB(n_ALUSrcB), .operation(n_operation), .state(n_state), .exception(n_exception),
    .instr_done(n_instr_done), .instr_count(n_instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] flags;  // PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,ALUSrcA,RegWrite,RegDst
    logic [1:0] pcs;
    logic [1:0] asb;
    logic [3:0] op;
    logic       done;
  } ctrl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         n;
    logic [3:0] st [6];
    int         chk_idx;
    ctrl_t      ctrl;
    int         cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;
  ctrl_t act_ctrl;

  assign act_ctrl = ctrl_t'({PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA,
                             RegWrite, RegDst, PCSource, ALUSrcB, operation, instr_done});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic add(input logic [5:0] op, input logic [5:0] funct, input logic zero, input int n,
                     input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                     input logic [3:0] s3, input logic [3:0] s4, input logic [3:0] s5,
                     input int chk_idx, input logic [18:0] ctrl, input int cnt);
    vec_t v;
    v.op = op; v.funct = funct; v.zero = zero; v.n = n;
    v.st[0] = s0; v.st[1] = s1; v.st[2] = s2; v.st[3] = s3; v.st[4] = s4; v.st[5] = s5;
    v.chk_idx = chk_idx; v.ctrl = ctrl_t'(ctrl); v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic cyc(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;
    // lw
    add(LW, 6'd0, 1'b0, 6, 0, 1, 2, 3, 4, 0, 4, {10'b0000001010, 2'b00, 2'b00, 4'b0010, 1'b1}, 1);
    add(LW, 6'd0, 1'b0, 6, 0, 1, 2, 3, 4, 0, 0, {10'b1001010000, 2'b00, 2'b01, 4'b0010, 1'b0}, 1);
    add(LW, 6'd0, 1'b0, 6, 0, 1, 2, 3, 4, 0, 2, {10'b0000000100, 2'b00, 2'b10, 4'b0010, 1'b0}, 1);
    add(LW, 6'd0, 1'b0, 6, 0, 1, 2, 3, 4, 0, 3, {10'b0011000000, 2'b00, 2'b00, 4'b0010, 1'b0}, 1);
    // sw
    add(SW, 6'd0, 1'b0, 5, 0, 1, 2, 5, 0, 0, 3, {10'b0010100000, 2'b00, 2'b00, 4'b0010, 1'b1}, 1);
    // R-type
    add(RT, 6'b100010, 1'b0, 5, 0, 1, 6, 7, 0, 0, 2, {10'b0000000100, 2'b00, 2'b00, 4'b0110, 1'b0}, 1);
    add(RT, 6'b100000, 1'b0, 5, 0, 1, 6, 7, 0, 0, 3, {10'b0000000011, 2'b00, 2'b00, 4'b0010, 1'b1}, 1);
    add(RT, 6'b100100, 1'b0, 5, 0, 1, 6, 7, 0, 0, 2, {10'b0000000100, 2'b00, 2'b00, 4'b0000, 1'b0}, 1);
    add(RT, 6'b100101, 1'b0, 5, 0, 1, 6, 7, 0, 0, 2, {10'b0000000100, 2'b00, 2'b00, 4'b0001, 1'b0}, 1);
    add(RT, 6'b101010, 1'b0, 5, 0, 1, 6, 7, 0, 0, 2, {10'b0000000100, 2'b00, 2'b00, 4'b0111, 1'b0}, 1);
    add(RT, 6'b000111, 1'b0, 5, 0, 1, 6, 15, 15, 0, -1, 19'd0, 0);
    // beq (both Zero values), j
    add(BEQ, 6'd0, 1'b1, 4, 0, 1, 8, 0, 0, 0, 2, {10'b0100000100, 2'b01, 2'b00, 4'b0110, 1'b1}, 1);
    add(BEQ, 6'd0, 1'b0, 4, 0, 1, 8, 0, 0, 0, 2, {10'b0100000100, 2'b01, 2'b00, 4'b0110, 1'b1}, 1);
    add(J,   6'd0, 1'b0, 4, 0, 1, 9, 0, 0, 0, 2, {10'b1000000000, 2'b10, 2'b00, 4'b0010, 1'b1}, 1);
    // addi, illegal opcode
    add(ADDI, 6'd0, 1'b0, 5, 0, 1, 10, 11, 0, 0, 1, {10'b0000000000, 2'b00, 2'b11, 4'b0010, 1'b0}, 1);
    add(ADDI, 6'd0, 1'b0, 5, 0, 1, 10, 11, 0, 0, 3, {10'b0000000010, 2'b00, 2'b00, 4'b0010, 1'b1}, 1);
    add(ADDI, 6'd0, 1'b0, 5, 0, 1, 10, 11, 0, 0, 2, {10'b0000000100, 2'b00, 2'b10, 4'b0010, 1'b0}, 1);
    add(6'b111111, 6'd0, 1'b0, 4, 0, 1, 15, 15, 0, 0, -1, 19'd0, 0);

    // Reset state, with mem_ready high so FETCH would otherwise enable writes.
    #2;
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", instr_count, 32'd0);
    check("rst_exc", 32'(exception), 32'd0);
    check("rst_done", 32'(instr_done), 32'd0);
    check("rst_wen", 32'({PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite}), 32'd0);

    foreach (vecs[v]) begin
      op_code = vecs[v].op; funct_field = vecs[v].funct; Zero = vecs[v].zero; mem_ready = 1'b1;
      do_reset();
      for (int k = 0; k < vecs[v].n; k++) begin
        #1;
        check($sformatf("v%0d_state%0d", v, k), 32'(state), 32'(vecs[v].st[k]));
        if (k == vecs[v].chk_idx) check($sformatf("v%0d_ctrl", v), 32'(act_ctrl), 32'(vecs[v].ctrl));
        @(posedge clk);
        @(negedge clk);
      end
      #1;
      check($sformatf("v%0d_count", v), instr_count, 32'(vecs[v].cnt));
      check($sformatf("v%0d_exc", v), 32'(exception), 32'(vecs[v].st[vecs[v].n-1] == 4'd15));
    end

    // FETCH held without ready: 8 wait cycles, then TRAP with no write enables.
    op_code = J; mem_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("to_state%0d", k), 32'(state), 32'd0);
      check($sformatf("to_wen%0d", k), 32'({IRWrite, PCWrite, RegWrite}), 32'd0);
      cyc(1);
    end
    #1;
    check("to_trap", 32'(state), 32'd15);
    check("to_exc", 32'(exception), 32'd1);
    check("to_count", instr_count, 32'd0);

    // Ready arrives on the 7th wait cycle: no trap.
    do_reset();
    cyc(6);
    mem_ready = 1'b1;
    #1;
    check("late_irwrite", 32'(IRWrite), 32'd1);
    cyc(1);
    #1;
    check("late_decode", 32'(state), 32'd1);
    check("late_exc", 32'(exception), 32'd0);

    // lw with a stalled MEMRD.
    op_code = LW; mem_ready = 1'b1;
    do_reset();
    cyc(3);
    mem_ready = 1'b0;
    cyc(3);
    #1;
    check("rdwait_state", 32'(state), 32'd3);
    mem_ready = 1'b1;
    cyc(1);
    #1;
    check("rdwait_wb", 32'(state), 32'd4);
    check("rdwait_done", 32'(instr_done), 32'd1);
    cyc(1);
    #1;
    check("rdwait_count", instr_count, 32'd1);

    // Asynchronous reset in MEMRD with a nonzero count.
    cyc(3);
    #1;
    check("ar_in_memrd", 32'(state), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("ar_state", 32'(state), 32'd0);
    check("ar_count", instr_count, 32'd0);
    check("ar_exc", 32'(exception), 32'd0);
    check("ar_irwrite", 32'({IRWrite, PCWrite}), 32'd0);
    @(negedge clk);

    // addi with ADDI_EN=0 traps, then asynchronous reset out of TRAP.
    op_code = ADDI;
    do_reset();
    cyc(2);
    #1;
    check("addi_en1", 32'(state), 32'd10);
    check("addi_en0", 32'(n_state), 32'd15);
    check("addi_en0_exc", 32'(n_exception), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("trap_rst_state", 32'(n_state), 32'd0);
    check("trap_rst_exc", 32'(n_exception), 32'd0);
    @(negedge clk);

    // Four jumps: 32-bit counter reads 4, 2-bit counter wraps to 0 (3 cycles each).
    op_code = J;
    do_reset();
    cyc(11);
    #1;
    check("wrap_pre32", instr_count, 32'd3);
    check("wrap_pre2", 32'(n_instr_count), 32'd3);
    cyc(1);
    #1;
    check("wrap_32", instr_count, 32'd4);
    check("wrap_2", 32'(n_instr_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
